iir_output_capture: RTL and testbench

//  Receiving end of the filter sample stream (VOUT/DOUT of IIRFilter).
//  - Captures a frame of FRAME_LEN valid samples into an on-chip FIFO.
//  - Keeps a running checksum and an overflow flag.
//  - A host drains the FIFO through a one-cycle-latency read port.
//  - Replaces the behavioural dataSink in system benches and on-board bring-up.

---
 rtl/iir_capture_pkg.sv | 24 ++
 rtl/iir_output_capture_sync_fifo.sv | 89 ++++++++
 rtl/iir_output_capture.sv | 124 ++++++++++++
 tb/tb_iir_output_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_capture_pkg.sv
// Shared types and helpers for the filter output capture block: FSM states,
// default widths and a width-generic sign extension.
package iir_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int NB_DEF    = 8;
    localparam int DEPTH_DEF = 16;
    localparam int CW_DEF    = 16;
    localparam int SEXT_W    = 64;

    // Sign-extends the low nb bits of x to SEXT_W bits; callers truncate to their own width.
    function automatic logic [SEXT_W-1:0] sign_ext(input logic [SEXT_W-1:0] x, input int nb);
        logic signed [SEXT_W-1:0] t;
        t = $signed(x << (SEXT_W - nb));
        return t >>> (SEXT_W - nb);
    endfunction

endpackage

// File: rtl/iir_output_capture_sync_fifo.sv
// Synchronous FIFO with registered read data; read data and valid appear one cycle after rd_en.
// A write into a full FIFO is refused unless a read pops in the same cycle; flush empties it and cancels that cycle's read.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid,
    input  logic                     flush,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_fire, wr_fire;

    always_comb begin
        rd_fire    = rd_en && !empty_q && !flush;
        wr_fire    = wr_en && !flush && (!full_q || rd_fire);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_fire;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (rd_fire) begin
                rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
                rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
            end
        end
        // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
        level_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign level    = level_q;

endmodule

// File: rtl/iir_output_capture.sv
// Captures a frame of filter samples into a FIFO with checksum/overflow; status and read data are registered (1 cycle).
// Never stalls the filter: samples arriving while the FIFO is full and unread are dropped and flagged in OVERFLOW.
module iir_output_capture
    import iir_capture_pkg::*;
#(
    parameter int NB        = NB_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int FRAME_LEN = 64,
    parameter int CW        = CW_DEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          ABORT,
    input  logic                          VIN,
    input  logic [NB-1:0]                 DIN,
    input  logic                          RD_EN,
    output logic [NB-1:0]                 RD_DATA,
    output logic                          RD_VALID,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic [$clog2(DEPTH):0]        LEVEL,
    output logic [$clog2(FRAME_LEN):0]    SAMPLE_CNT,
    output logic [CW-1:0]                 CHECKSUM,
    output logic                          OVERFLOW,
    output logic                          BUSY,
    output logic                          DONE
);

    localparam int CNTW = $clog2(FRAME_LEN) + 1;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]   cks_q, cks_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fifo_wr;
    logic            room;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cks_d   = cks_q;
        ovf_d   = ovf_q;
        fifo_wr = 1'b0;
        cnt_inc = cnt_q + CNTW'(1);
        // A full FIFO still takes the sample when the host pops in the same cycle.
        room    = !FULL || (RD_EN && !EMPTY);

        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        cks_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (VIN) begin
                        cnt_d = cnt_inc;
                        if (room) begin
                            fifo_wr = 1'b1;
                            cks_d   = cks_q + CW'(sign_ext(SEXT_W'(DIN), NB));
                        end else begin
                            ovf_d = 1'b1;
                        end
                        state_d = (cnt_inc == CNTW'(FRAME_LEN)) ? ST_DONE : ST_CAPTURE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cks_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cks_q   <= cks_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    sync_fifo #(
        .W     (NB),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_en    (fifo_wr),
        .wr_data  (DIN),
        .rd_en    (RD_EN),
        .rd_data  (RD_DATA),
        .rd_valid (RD_VALID),
        .flush    (ABORT),
        .empty    (EMPTY),
        .full     (FULL),
        .level    (LEVEL)
    );

    assign SAMPLE_CNT = cnt_q;
    assign CHECKSUM   = cks_q;
    assign OVERFLOW   = ovf_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_iir_output_capture.sv
// Two capture instances (FRAME_LEN 4 and 20) share one stimulus stream and are checked
// every cycle against a queue-based frame model, plus literal scenario checks.
module tb_iir_output_capture;

    localparam int DEPTH = 16;
    localparam int FL0   = 4;
    localparam int FL1   = 20;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;

    logic       clk, rst, start, abort, vin, rd_en;
    logic [7:0] din;

    logic [7:0]  rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, empty0, empty1, full0, full1;
    logic [4:0]  level0, level1;
    logic [2:0]  cnt0;
    logic [5:0]  cnt1;
    logic [15:0] cks0, cks1;
    logic        ovf0, ovf1, busy0, busy1, done0, done1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int m_st [2], m_cnt [2], m_cks [2], m_rdd [2];
    bit m_ovf [2], m_rdv [2];
    logic [7:0] exp1 [4];

    iir_output_capture #(.NB(8), .DEPTH(DEPTH), .FRAME_LEN(FL0), .CW(16)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .VIN(vin), .DIN(din),
        .RD_EN(rd_en), .RD_DATA(rd_data0), .RD_VALID(rd_valid0), .EMPTY(empty0),
        .FULL(full0), .LEVEL(level0), .SAMPLE_CNT(cnt0), .CHECKSUM(cks0),
        .OVERFLOW(ovf0), .BUSY(busy0), .DONE(done0)
    );

    iir_output_capture #(.NB(8), .DEPTH(DEPTH), .FRAME_LEN(FL1), .CW(16)) dut1 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .VIN(vin), .DIN(din),
        .RD_EN(rd_en), .RD_DATA(rd_data1), .RD_VALID(rd_valid1), .EMPTY(empty1),
        .FULL(full1), .LEVEL(level1), .SAMPLE_CNT(cnt1), .CHECKSUM(cks1),
        .OVERFLOW(ovf1), .BUSY(busy1), .DONE(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = S_IDLE; m_cnt[k] = 0; m_cks[k] = 0; m_rdd[k] = 0;
            m_ovf[k] = 0; m_rdv[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input int flen);
        logic [7:0] q [$];
        bit rd;
        if (k == 0) q = q0; else q = q1;
        rd = rd_en && (q.size() > 0) && !abort;
        m_rdv[k] = 0;
        if (abort) begin
            q.delete();
            m_st[k] = S_IDLE;
        end else begin
            if (rd) begin
                m_rdd[k] = int'(q.pop_front());
                m_rdv[k] = 1;
            end
            if (m_st[k] == S_IDLE || m_st[k] == S_DONE) begin
                if (start) begin
                    m_st[k] = S_ARMED; m_cnt[k] = 0; m_cks[k] = 0; m_ovf[k] = 0;
                end
            end else if (vin) begin
                m_cnt[k]++;
                if (q.size() < DEPTH) begin
                    q.push_back(din);
                    m_cks[k] = (m_cks[k] + int'($signed(din))) & 32'hFFFF;
                end else begin
                    m_ovf[k] = 1;
                end
                m_st[k] = (m_cnt[k] == flen) ? S_DONE : S_CAPTURE;
            end
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0, FL0);
            model_step(1, FL1);
        end
    end

    always @(negedge clk) begin
        chk("i0_rd_valid", int'(rd_valid0), int'(m_rdv[0]));
        chk("i0_rd_data",  int'(rd_data0),  m_rdd[0]);
        chk("i0_empty",    int'(empty0),    int'(q0.size() == 0));
        chk("i0_full",     int'(full0),     int'(q0.size() == DEPTH));
        chk("i0_level",    int'(level0),    q0.size());
        chk("i0_cnt",      int'(cnt0),      m_cnt[0]);
        chk("i0_checksum", int'(cks0),      m_cks[0]);
        chk("i0_overflow", int'(ovf0),      int'(m_ovf[0]));
        chk("i0_busy",     int'(busy0),     int'(m_st[0] == S_ARMED || m_st[0] == S_CAPTURE));
        chk("i0_done",     int'(done0),     int'(m_st[0] == S_DONE));
        chk("i1_rd_valid", int'(rd_valid1), int'(m_rdv[1]));
        chk("i1_rd_data",  int'(rd_data1),  m_rdd[1]);
        chk("i1_empty",    int'(empty1),    int'(q1.size() == 0));
        chk("i1_full",     int'(full1),     int'(q1.size() == DEPTH));
        chk("i1_level",    int'(level1),    q1.size());
        chk("i1_cnt",      int'(cnt1),      m_cnt[1]);
        chk("i1_checksum", int'(cks1),      m_cks[1]);
        chk("i1_overflow", int'(ovf1),      int'(m_ovf[1]));
        chk("i1_busy",     int'(busy1),     int'(m_st[1] == S_ARMED || m_st[1] == S_CAPTURE));
        chk("i1_done",     int'(done1),     int'(m_st[1] == S_DONE));
    end

    task automatic drive(input bit s, input bit a, input bit v, input logic [7:0] d, input bit r);
        start = s; abort = a; vin = v; din = d; rd_en = r;
        @(posedge clk);
        #1;
        start = 0; abort = 0; vin = 0; rd_en = 0;
    endtask

    initial begin
        exp1[0] = 8'h05; exp1[1] = 8'hFD; exp1[2] = 8'h7F; exp1[3] = 8'h80;
        rst = 1; start = 0; abort = 0; vin = 0; din = 0; rd_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty0), 1);
        chk("rst_level", int'(level0), 0);
        chk("rst_busy",  int'(busy0),  0);
        rst = 0;

        // Read of an empty FIFO and VIN while idle have no effect.
        drive(0, 0, 0, 8'h00, 1);
        chk("t4_rd_valid_empty", int'(rd_valid0), 0);
        drive(0, 0, 1, 8'h33, 0);
        chk("t4_idle_level", int'(level0), 0);
        chk("t4_idle_cnt",   int'(cnt0),   0);

        // Four-sample frame and drain.
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h05, 0);
        drive(0, 0, 1, 8'hFD, 0);
        drive(0, 0, 1, 8'h7F, 0);
        drive(0, 0, 1, 8'h80, 0);
        chk("t1_done",     int'(done0), 1);
        chk("t1_cnt",      int'(cnt0),  4);
        chk("t1_checksum", int'(cks0),  16'h0001);
        chk("t1_model_cks", m_cks[0],   1);
        chk("t1_level",    int'(level0), 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 8'h00, 1);
            chk("t1_rd_valid", int'(rd_valid0), 1);
            chk("t1_rd_data",  int'(rd_data0),  int'(exp1[i]));
        end

        // Twenty samples of 1 into a 16-deep FIFO, no reads.
        drive(0, 1, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 8'h01, 0);
            if (i == 14) chk("t2_not_full_15", int'(full1), 0);
            if (i == 15) chk("t2_full_16",     int'(full1), 1);
        end
        chk("t2_full",     int'(full1), 1);
        chk("t2_overflow", int'(ovf1),  1);
        chk("t2_cnt",      int'(cnt1),  20);
        chk("t2_checksum", int'(cks1),  16);
        chk("t2_level",    int'(level1), 16);
        chk("t2_done",     int'(done1), 1);

        // Full FIFO, write and read in one cycle.
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h09, 1);
        chk("t3_level",    int'(level1),    16);
        chk("t3_overflow", int'(ovf1),      0);
        chk("t3_rd_valid", int'(rd_valid1), 1);
        chk("t3_rd_data",  int'(rd_data1),  1);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 8'h00, 1);
        chk("t3_last_data", int'(rd_data1), 9);
        chk("t3_empty",     int'(empty1),   1);

        // Abort mid-frame, then a clean frame.
        drive(0, 1, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h11, 0);
        drive(0, 0, 1, 8'h22, 0);
        drive(0, 1, 0, 8'h00, 0);
        chk("t5_busy",  int'(busy0),  0);
        chk("t5_level", int'(level0), 0);
        chk("t5_done",  int'(done0),  0);
        drive(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'(i + 1), 0);
        chk("t5_done2", int'(done0), 1);
        chk("t5_cnt2",  int'(cnt0),  4);

        // Asynchronous reset mid-capture.
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 1, 8'h0A, 0);
        drive(0, 0, 1, 8'h14, 0);
        #3 rst = 1;
        #1;
        chk("t6_busy",     int'(busy0),     0);
        chk("t6_level",    int'(level0),    0);
        chk("t6_cnt",      int'(cnt0),      0);
        chk("t6_checksum", int'(cks0),      0);
        chk("t6_empty",    int'(empty0),    1);
        chk("t6_rd_data",  int'(rd_data0),  0);
        @(posedge clk);
        #1 rst = 0;
        drive(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'hFF, 0);
        chk("t6_done",     int'(done0), 1);
        chk("t6_cnt2",     int'(cnt0),  4);
        chk("t6_checksum2", int'(cks0), 16'hFFFC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
